// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter: round-robin 2:1 OBI arbiter with optional grant stall and in-order response routing
module obi_mem_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     instr_req_i,
    input  logic [31:0]              instr_addr_i,
    output logic                     instr_gnt_o,
    output logic                     instr_rvalid_o,
    output logic [31:0]              instr_rdata_o,
    input  logic                     data_req_i,
    input  logic [31:0]              data_addr_i,
    input  logic                     data_we_i,
    input  logic [3:0]               data_be_i,
    input  logic [31:0]              data_wdata_i,
    output logic                     data_gnt_o,
    output logic                     data_rvalid_o,
    output logic [31:0]              data_rdata_o,
    output logic                     mem_req_o,
    output logic [31:0]              mem_addr_o,
    output logic                     mem_we_o,
    output logic [3:0]               mem_be_o,
    output logic [31:0]              mem_wdata_o,
    input  logic                     mem_gnt_i,
    input  logic                     mem_rvalid_i,
    input  logic [31:0]              mem_rdata_i,
    input  logic                     en_gnt_stall_i,
    input  logic [3:0]               gnt_stall_i,
    output logic [$clog2(DEPTH):0]   outstanding_o,
    output logic                     err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, WAIT, REQ} state_t;

    state_t           r_state;
    logic             r_owner;
    logic             r_last_owner;
    logic             r_err;
    logic [3:0]       r_cnt;
    logic [DEPTH-1:0] r_fifo;
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;

    logic             w_owner_req;
    logic             w_push;
    logic             w_pop;
    logic             w_head;
    logic             w_last;
    logic             w_win;
    logic             w_can_arb;
    logic             w_arb;
    logic [AW:0]      w_occ;
    logic [AW:0]      w_occ_next;

    // Arbitration decision; the grant cycle uses the just-granted owner as last_owner
    always_comb begin
        w_occ       = r_wptr - r_rptr;
        w_owner_req = r_owner ? data_req_i : instr_req_i;
        w_push      = (r_state == REQ) & mem_gnt_i & w_owner_req;
        w_pop       = mem_rvalid_i & (w_occ != '0);
        w_head      = r_fifo[r_rptr[AW-1:0]];
        w_occ_next  = w_occ + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        w_last      = w_push ? r_owner : r_last_owner;
        w_win       = (instr_req_i & data_req_i) ? ~w_last : data_req_i;
        w_can_arb   = (instr_req_i | data_req_i) & (w_occ != FULL) & (w_occ_next < FULL);
        w_arb       = (r_state == IDLE) | w_push;
    end

    // Control FSM: owner selection, stall countdown, retraction and stray-response errors
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b0;
            r_cnt        <= 4'd0;
            r_err        <= 1'b0;
        end else begin
            if (w_push) r_last_owner <= r_owner;
            if (r_state != IDLE && !w_owner_req) begin
                r_err   <= 1'b1;
                r_state <= IDLE;
            end else if (w_arb) begin
                if (w_can_arb) begin
                    r_owner <= w_win;
                    if (en_gnt_stall_i && gnt_stall_i != 4'd0) begin
                        r_cnt   <= gnt_stall_i;
                        r_state <= WAIT;
                    end else begin
                        r_state <= REQ;
                    end
                end else begin
                    r_state <= IDLE;
                end
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
                if (r_cnt == 4'd1) r_state <= REQ;
            end
            if (mem_rvalid_i && w_occ == '0) r_err <= 1'b1;
        end
    end

    // ID FIFO pointers; the extra wrap bit separates full from empty
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + ONE;
            if (w_pop) r_rptr <= r_rptr + ONE;
        end
    end

    // ID FIFO storage: which master issued each granted transaction
    always_ff @(posedge clk_i) begin
        if (w_push) r_fifo[r_wptr[AW-1:0]] <= r_owner;
    end

    // Shared port muxing, grant steering and response routing
    always_comb begin
        mem_req_o      = r_state == REQ;
        mem_addr_o     = r_owner ? data_addr_i : instr_addr_i;
        mem_we_o       = r_owner & data_we_i;
        mem_be_o       = r_owner ? data_be_i : 4'hF;
        mem_wdata_o    = r_owner ? data_wdata_i : 32'd0;
        instr_gnt_o    = (r_state == REQ) & mem_gnt_i & ~r_owner;
        data_gnt_o     = (r_state == REQ) & mem_gnt_i & r_owner;
        instr_rvalid_o = w_pop & ~w_head;
        data_rvalid_o  = w_pop & w_head;
        instr_rdata_o  = mem_rdata_i;
        data_rdata_o   = mem_rdata_i;
        outstanding_o  = w_occ;
        err_o          = r_err;
    end
endmodule

// File: tb/tb_obi_mem_arbiter.sv
// tb_obi_mem_arbiter: directed and random checks of obi_mem_arbiter against a transaction-level model
module tb_obi_mem_arbiter;
    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_req_i, instr_gnt_o, instr_rvalid_o;
    logic [31:0] instr_addr_i, instr_rdata_o;
    logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic [3:0]  data_be_i;
    logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_be_o;
    logic        en_gnt_stall_i;
    logic [3:0]  gnt_stall_i;
    logic [2:0]  outstanding_o;
    logic        err_o;

    int n_vec = 0;
    int n_err = 0;

    bit m_busy, m_own, m_last, m_err;
    int m_wait;
    bit m_q[$];
    bit i_hold, d_hold;

    obi_mem_arbiter #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .en_gnt_stall_i(en_gnt_stall_i), .gnt_stall_i(gnt_stall_i),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        instr_req_i = 0; instr_addr_i = 0; data_req_i = 0; data_addr_i = 0;
        data_we_i = 0; data_be_i = 0; data_wdata_i = 0; mem_gnt_i = 0;
        mem_rvalid_i = 0; mem_rdata_i = 0; en_gnt_stall_i = 0; gnt_stall_i = 0;
        i_hold = 0; d_hold = 0;
    endtask

    // called right after a falling edge; leaves the bench just after the next falling edge
    task automatic do_reset();
        #2 rst_ni = 1'b0;
        clear_inputs();
        m_busy = 0; m_own = 0; m_last = 0; m_err = 0; m_wait = 0;
        m_q.delete();
        #1;
        chk("rst_occ", outstanding_o, 0);
        chk("rst_req", mem_req_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_gnt", {instr_gnt_o, data_gnt_o}, 0);
        chk("rst_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // check all outputs against the model for the current inputs, then advance model and clock
    task automatic cycle();
        bit rq, ig, dg, pop, push, own_req, full;
        int nsz;
        #1;
        rq  = m_busy && m_wait == 0;
        pop = mem_rvalid_i && m_q.size() > 0;
        ig  = rq && mem_gnt_i && !m_own;
        dg  = rq && mem_gnt_i && m_own;
        chk("mem_req", mem_req_o, rq);
        chk("instr_gnt", instr_gnt_o, ig);
        chk("data_gnt", data_gnt_o, dg);
        chk("instr_rvalid", instr_rvalid_o, pop && m_q[0] == 1'b0);
        chk("data_rvalid", data_rvalid_o, pop && m_q[0] == 1'b1);
        chk("outstanding", outstanding_o, m_q.size());
        chk("err", err_o, m_err);
        chk("instr_rdata", instr_rdata_o, mem_rdata_i);
        chk("data_rdata", data_rdata_o, mem_rdata_i);
        if (rq) begin
            chk("mem_addr", mem_addr_o, m_own ? data_addr_i : instr_addr_i);
            chk("mem_we", mem_we_o, m_own ? data_we_i : 1'b0);
            chk("mem_be", mem_be_o, m_own ? data_be_i : 4'hF);
            chk("mem_wdata", mem_wdata_o, m_own ? data_wdata_i : 32'd0);
        end
        own_req = m_own ? data_req_i : instr_req_i;
        push = rq && mem_gnt_i && own_req;
        full = m_q.size() == DEPTH;
        nsz = m_q.size() + int'(push) - int'(pop);
        if (mem_rvalid_i && m_q.size() == 0) m_err = 1;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            m_q.push_back(m_own);
            m_last = m_own;
        end
        if (m_busy && !own_req) begin
            m_err = 1;
            m_busy = 0;
        end else if (!m_busy || push) begin
            if ((instr_req_i || data_req_i) && !full && nsz < DEPTH) begin
                m_own  = (instr_req_i && data_req_i) ? !m_last : data_req_i;
                m_wait = (en_gnt_stall_i && gnt_stall_i != 0) ? int'(gnt_stall_i) : 0;
                m_busy = 1;
            end else begin
                m_busy = 0;
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end
        if (ig) i_hold = 0;
        if (dg) d_hold = 0;
        @(negedge clk_i);
    endtask

    initial begin
        int lat;
        rst_ni = 1'b0;
        clear_inputs();
        do_reset();

        // single instruction read
        do_reset();
        instr_req_i = 1; instr_addr_i = 32'h100; mem_gnt_i = 1;
        cycle();
        #1;
        chk("rd_req", mem_req_o, 1);
        chk("rd_addr", mem_addr_o, 32'h100);
        chk("rd_be", mem_be_o, 4'hF);
        chk("rd_ignt", instr_gnt_o, 1);
        cycle();
        instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
        #1;
        chk("rd_rvalid", instr_rvalid_o, 1);
        chk("rd_rdata", instr_rdata_o, 32'hDEADBEEF);
        chk("rd_drvalid", data_rvalid_o, 0);
        cycle();
        mem_rvalid_i = 0;

        // conflict order, full FIFO, in-order routing
        do_reset();
        instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1;
        instr_addr_i = 32'h300; data_addr_i = 32'h200; data_we_i = 1; data_be_i = 4'h3; data_wdata_i = 32'h1234;
        cycle();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("cf_dgnt", data_gnt_o, k % 2 == 0);
            chk("cf_ignt", instr_gnt_o, k % 2);
            cycle();
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("full_occ", outstanding_o, 4);
            chk("full_req", mem_req_o, 0);
            cycle();
        end
        for (int k = 0; k < 4; k++) begin
            mem_rvalid_i = 1; mem_rdata_i = $urandom;
            #1;
            chk("cf_drv", data_rvalid_o, k % 2 == 0);
            chk("cf_irv", instr_rvalid_o, k % 2);
            cycle();
        end
        mem_rvalid_i = 0;
        for (int k = 0; k < 4; k++) cycle();

        // grant stall, stall length changed mid-count
        do_reset();
        en_gnt_stall_i = 1; gnt_stall_i = 3; data_req_i = 1; data_addr_i = 32'h40;
        cycle();
        gnt_stall_i = 0;
        lat = 1;
        while (lat < 10) begin
            #1;
            if (mem_req_o) break;
            cycle();
            lat++;
        end
        chk("stall_lat", lat, 4);
        cycle();

        // stray response on empty FIFO
        do_reset();
        mem_rvalid_i = 1;
        #1;
        chk("stray_rv", {instr_rvalid_o, data_rvalid_o}, 0);
        cycle();
        mem_rvalid_i = 0;
        chk("stray_err", err_o, 1);
        cycle();

        // retraction during WAIT
        do_reset();
        en_gnt_stall_i = 1; gnt_stall_i = 5; data_req_i = 1;
        cycle();
        cycle();
        data_req_i = 0;
        cycle();
        chk("retr_err", err_o, 1);
        chk("retr_occ", outstanding_o, 0);
        cycle();

        // reset with transactions in flight
        do_reset();
        instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1;
        for (int k = 0; k < 3; k++) cycle();
        chk("pre_rst_occ", outstanding_o, 2);
        do_reset();
        mem_rvalid_i = 1;
        cycle();
        mem_rvalid_i = 0;
        chk("post_rst_err", err_o, 1);

        // randomized traffic
        for (int n = 0; n < 2400; n++) begin
            if (n % 300 == 0) do_reset();
            if (!i_hold && $urandom_range(0, 3) != 0) begin
                i_hold = 1; instr_addr_i = $urandom;
            end
            if (!d_hold && $urandom_range(0, 3) != 0) begin
                d_hold = 1; data_addr_i = $urandom; data_we_i = 1'($urandom);
                data_be_i = 4'($urandom); data_wdata_i = $urandom;
            end
            if ($urandom_range(0, 99) == 0) i_hold = 0;
            if ($urandom_range(0, 99) == 0) d_hold = 0;
            instr_req_i = i_hold;
            data_req_i = d_hold;
            mem_gnt_i = $urandom_range(0, 3) != 0;
            mem_rvalid_i = (m_q.size() > 0 && $urandom_range(0, 2) != 0) || $urandom_range(0, 299) == 0;
            mem_rdata_i = $urandom;
            if ($urandom_range(0, 19) == 0) begin
                en_gnt_stall_i = $urandom_range(0, 2) == 0;
                gnt_stall_i = 4'($urandom);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
